// File: rtl/nor_unit_arbiter.sv
// nor_unit_arbiter
//   Shares one registered NOR datapath (rsp_data = ~(a | b)) between N_REQ
//   requesters. A round-robin arbiter picks one requester per operation; a
//   two-state sequencer grants it (capturing its operands), then executes
//   and returns a tagged response. One operation per two cycles at most.
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   req        per-requester request level, bit i = requester i
//   a_in/b_in  packed operands, slice [i*WIDTH +: WIDTH] = requester i
//   gnt        registered one-hot grant pulse (cycle after the request edge)
//   rsp_valid  registered result-valid pulse (cycle after gnt)
//   rsp_id     requester index owning rsp_data (holds until next response)
//   rsp_data   NOR result (holds until next response)
//   busy       high while an operation is in flight (the gnt cycle)
module nor_unit_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8,
  localparam int IDW = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] a_in,
  input  logic [N_REQ*WIDTH-1:0] b_in,
  output logic [N_REQ-1:0]       gnt,
  output logic                   rsp_valid,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_data,
  output logic                   busy
);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_EXEC = 1'b1;

  // N_REQ expressed in the width used for the wrapped scan index; IDW+1 bits
  // always hold N_REQ (e.g. 16 needs 5 bits).
  localparam logic [IDW:0] NREQ_W = (IDW+1)'(N_REQ);

  // First set request at or after ptr, wrapping modulo N_REQ.
  function automatic logic [IDW-1:0] pick_winner(input logic [N_REQ-1:0] r,
                                                 input logic [IDW-1:0]   p);
    logic [IDW-1:0] w;
    logic           found;
    logic [IDW:0]   idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = {1'b0, p} + (IDW+1)'(k);
      if (idx >= NREQ_W) idx = idx - NREQ_W;
      if (!found && r[idx[IDW-1:0]]) begin
        w     = idx[IDW-1:0];
        found = 1'b1;
      end
    end
    return w;
  endfunction

  function automatic logic [WIDTH-1:0] nor_op(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    return ~(a | b);
  endfunction

  logic           state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win;
  logic [IDW-1:0] next_ptr;
  logic [WIDTH-1:0] a_sel, b_sel;
  logic [WIDTH-1:0] a_lat_p1, b_lat_p1;
  logic [IDW-1:0]   id_p1;

  // Only the winning slice is routed, so X on other slices cannot leak.
  always_comb begin
    win   = pick_winner(req, ptr);
    a_sel = '0;
    b_sel = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        a_sel = a_in[i*WIDTH +: WIDTH];
        b_sel = b_in[i*WIDTH +: WIDTH];
      end
    end
    next_ptr = (win == IDW'(N_REQ-1)) ? '0 : win + IDW'(1);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      ptr       <= '0;
      a_lat_p1  <= '0;
      b_lat_p1  <= '0;
      id_p1     <= '0;
      gnt       <= '0;
      busy      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= 1'b0;
      case (state)
        // ---- stage 1: arbitrate, grant, capture operands ----
        S_IDLE: begin
          if (|req) begin
            a_lat_p1 <= a_sel;
            b_lat_p1 <= b_sel;
            id_p1    <= win;
            gnt      <= N_REQ'(1) << win;
            busy     <= 1'b1;
            ptr      <= next_ptr;
            state    <= S_EXEC;
          end
        end
        // ---- stage 2: execute and respond; req is ignored here ----
        S_EXEC: begin
          rsp_data  <= nor_op(a_lat_p1, b_lat_p1);
          rsp_id    <= id_p1;
          rsp_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nor_unit_arbiter.sv
module tb_nor_unit_arbiter;

  logic        clk;
  logic        resetn;
  logic [3:0]  req;
  logic [31:0] a_in, b_in;
  logic [3:0]  gnt;
  logic        rsp_valid;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;

  int checks;
  int errors;

  nor_unit_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk(clk), .resetn(resetn), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  gnt;   // 0 = no operation expected
    logic [1:0]  id;    // expected rsp_id (held value when idle)
    logic [7:0]  data;  // expected rsp_data (held value when idle)
  } vec_t;

  vec_t tv[11];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  int          mptr;
  int          w;
  int          waitc[4];
  int          max_wait;
  logic [3:0]  r;
  logic [31:0] av, bv;
  logic [7:0]  expd;

  initial begin
    checks = 0;
    errors = 0;

    // Single request, then rotation 1,2,3,0,1,2 with req=1111 held
    tv[0]  = '{4'b0001, 32'h0000_000F, 32'h0000_0030, 4'b0001, 2'd0, 8'hC0};
    tv[1]  = '{4'b1111, 32'h8040_2010, 32'h0102_0408, 4'b0010, 2'd1, 8'hDB};
    tv[2]  = '{4'b1111, 32'h1122_3344, 32'h0000_0000, 4'b0100, 2'd2, 8'hDD};
    tv[3]  = '{4'b1111, 32'hF000_0000, 32'h0F00_0000, 4'b1000, 2'd3, 8'h00};
    tv[4]  = '{4'b1111, 32'h0000_00A0, 32'h0000_0005, 4'b0001, 2'd0, 8'h5A};
    tv[5]  = '{4'b1111, 32'h0000_1200, 32'h0000_0300, 4'b0010, 2'd1, 8'hEC};
    tv[6]  = '{4'b1111, 32'h0081_0000, 32'h0018_0000, 4'b0100, 2'd2, 8'h66};
    // ptr=3: lone req 1 wins (ptr->2), then 1001 gives 3 first, then 0
    tv[7]  = '{4'b0010, 32'h0000_3C00, 32'h0000_0000, 4'b0010, 2'd1, 8'hC3};
    tv[8]  = '{4'b1001, 32'h7700_0011, 32'h0800_0022, 4'b1000, 2'd3, 8'h80};
    tv[9]  = '{4'b1001, 32'h7700_0011, 32'h0800_0022, 4'b0001, 2'd0, 8'hCC};
    // idle: nothing granted, response fields hold
    tv[10] = '{4'b0000, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0000, 2'd0, 8'hCC};

    // ---- reset held across edges with random inputs ----
    resetn = 1'b0;
    req = 4'b0000; a_in = '0; b_in = '0;
    for (int i = 0; i < 3; i++) begin
      req  = 4'($urandom_range(0, 15));
      a_in = $urandom;
      b_in = $urandom;
      tick();
      check("rst_gnt", gnt, 0);
      check("rst_valid", rsp_valid, 0);
      check("rst_id", rsp_id, 0);
      check("rst_data", rsp_data, 0);
      check("rst_busy", busy, 0);
    end
    req = 4'b0000;
    resetn = 1'b1;
    tick();

    // ---- table: operands inverted during EXEC to prove capture at grant ----
    for (int i = 0; i < 11; i++) begin
      req  = tv[i].req;
      a_in = tv[i].a;
      b_in = tv[i].b;
      tick();
      if (tv[i].gnt != 4'b0000) begin
        check($sformatf("v%0d_gnt", i), gnt, tv[i].gnt);
        check($sformatf("v%0d_busy", i), busy, 1);
        check($sformatf("v%0d_valid_early", i), rsp_valid, 0);
        a_in = ~tv[i].a;
        b_in = ~tv[i].b;
        tick();
        check($sformatf("v%0d_valid", i), rsp_valid, 1);
        check($sformatf("v%0d_id", i), rsp_id, tv[i].id);
        check($sformatf("v%0d_data", i), rsp_data, tv[i].data);
        check($sformatf("v%0d_gnt_low", i), gnt, 0);
        check($sformatf("v%0d_busy_low", i), busy, 0);
      end else begin
        check($sformatf("v%0d_idle_gnt", i), gnt, 0);
        check($sformatf("v%0d_idle_busy", i), busy, 0);
        check($sformatf("v%0d_idle_valid", i), rsp_valid, 0);
        check($sformatf("v%0d_hold_id", i), rsp_id, tv[i].id);
        check($sformatf("v%0d_hold_data", i), rsp_data, tv[i].data);
      end
    end

    // ---- reset during EXEC: async clear, no response, ptr back to 0 ----
    req = 4'b0001; a_in = 32'h0000_0003; b_in = 32'h0;
    tick();
    check("rx_gnt", gnt, 4'b0001);
    #2;
    resetn = 1'b0;
    #1;
    check("rx_async_gnt", gnt, 0);
    check("rx_async_busy", busy, 0);
    check("rx_async_data", rsp_data, 0);
    tick();
    check("rx_no_valid", rsp_valid, 0);
    resetn = 1'b1;
    req = 4'b0011; a_in = 32'h0000_4001; b_in = 32'h0000_0002;
    tick();
    check("rx_after_gnt", gnt, 4'b0001);
    req = 4'b0000;
    tick();
    check("rx_after_valid", rsp_valid, 1);
    check("rx_after_id", rsp_id, 0);
    check("rx_after_data", rsp_data, 8'hFC);

    // ---- X on unselected request bit and operand slices (ptr=1) ----
    req = 4'bx010; a_in = 32'hxxxx_5Axx; b_in = 32'hxxxx_21xx;
    tick();
    check("x_gnt", gnt, 4'b0010);
    a_in = 'x; b_in = 'x;
    tick();
    check("x_valid", rsp_valid, 1);
    check("x_id", rsp_id, 1);
    check("x_data", rsp_data, 8'h84);
    req = 4'b0000; a_in = '0; b_in = '0;

    // ---- random soak against a round-robin reference ----
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    mptr = 0;
    max_wait = 0;
    for (int i = 0; i < 4; i++) waitc[i] = 0;
    for (int n = 0; n < 200; n++) begin
      r  = 4'($urandom_range(0, 15));
      av = $urandom;
      bv = $urandom;
      req = r; a_in = av; b_in = bv;
      tick();
      if (r == 4'b0000) begin
        check("soak_idle_gnt", gnt, 0);
        check("soak_idle_valid", rsp_valid, 0);
      end else begin
        w = -1;
        for (int k = 0; k < 4; k++) begin
          if (w < 0 && r[(mptr + k) % 4]) w = (mptr + k) % 4;
        end
        check("soak_gnt", gnt, 4'b0001 << w);
        for (int i = 0; i < 4; i++) begin
          if (r[i] && !gnt[i]) waitc[i]++;
          else waitc[i] = 0;
          if (waitc[i] > max_wait) max_wait = waitc[i];
        end
        mptr = (w + 1) % 4;
        expd = ~(av[w*8 +: 8] | bv[w*8 +: 8]);
        a_in = $urandom;
        b_in = $urandom;
        tick();
        check("soak_valid", rsp_valid, 1);
        check("soak_id", rsp_id, w);
        check("soak_data", rsp_data, expd);
      end
    end
    checks++;
    if (max_wait > 3) begin
      errors++;
      $display("FAIL starvation: got %0d waits expected at most 3", max_wait);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
